fp_normalizer: RTL and testbench

Post-add normalization stage of the basic adder datapath. Takes the raw significand sum (carry + hidden + fraction + 3 guard bits) with its tentative exponent and sign. Produces a significand whose hidden bit is set, in exactly the `{hidden, fraction, G, R, S}` layout the rounding stage consumes. Normalization is iterative, up to `SHIFT_PER_CYC` left-shift positions per cycle, with a valid/ready handshake on both sides. It also raises zero, exponent-overflow and underflow (denormal) flags.

---
 rtl/fp_normalizer.sv | 227 ++++++++++++++++++++++
 tb/tb_fp_normalizer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_normalizer.sv
// Post-add normalization stage: takes the raw significand sum and realigns it so the hidden bit is set.
// Applies a carry right-shift or an iterative left-shift, adjusts the exponent, and raises the zero/ovf/unf flags.
module fp_normalizer #(
  parameter int Significant_WD = 23,
  parameter int Exponent_WD    = 8,
  parameter int SHIFT_PER_CYC  = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [Significant_WD+4:0]   Sum_in,
  input  logic [Exponent_WD-1:0]      Exp_in,
  input  logic                        Sign_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [Significant_WD+3:0]   MOut,
  output logic [Exponent_WD-1:0]      Exp_out,
  output logic                        Sign_out,
  output logic                        zero_flag,
  output logic                        ovf_flag,
  output logic                        unf_flag
);

  localparam int SW  = Significant_WD + 4;
  localparam int HID = SW - 1;
  localparam int EXW = Exponent_WD + 1;
  localparam logic [EXW-1:0] EXP_ONE  = EXW'(1);
  localparam logic [EXW-1:0] EXP_ONES = {1'b0, {Exponent_WD{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_nx;
  logic [SW-1:0]    work_sig_r, work_sig_nx;
  logic [EXW-1:0]   work_exp_r, work_exp_nx;
  logic             work_sign_r, work_sign_nx;

  logic             fin_s;
  logic [SW-1:0]    fin_sig_s;
  logic [EXW-1:0]   fin_exp_s;
  logic             fin_sign_s;
  logic             fin_zero_s;
  logic             fin_ovf_s;
  logic             fin_unf_s;

  logic [EXW-1:0]   e_in_s;
  logic [EXW-1:0]   e_inc_s;
  logic [31:0]      lz_s;
  logic [31:0]      lim_s;
  logic [31:0]      shift_s;
  logic [SW-1:0]    shifted_s;
  logic [EXW-1:0]   shexp_s;

  function automatic logic [31:0] clz(input logic [SW-1:0] v);
    logic [31:0] n;
    logic        found;
    n     = 32'd0;
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) begin
          found = 1'b1;
        end else begin
          n = n + 32'd1;
        end
      end
    end
    return n;
  endfunction

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state, normalization step and result selection
  always_comb begin
    state_nx     = state_r;
    work_sig_nx  = work_sig_r;
    work_exp_nx  = work_exp_r;
    work_sign_nx = work_sign_r;
    fin_s        = 1'b0;
    fin_sig_s    = {SW{1'b0}};
    fin_exp_s    = {EXW{1'b0}};
    fin_sign_s   = work_sign_r;
    fin_zero_s   = 1'b0;
    fin_ovf_s    = 1'b0;
    fin_unf_s    = 1'b0;

    e_in_s  = (Exp_in == {Exponent_WD{1'b0}}) ? EXP_ONE : {1'b0, Exp_in};
    e_inc_s = e_in_s + EXP_ONE;

    // Shift is capped so the exponent never drops below 1 (denormal boundary)
    lz_s  = clz(work_sig_r);
    lim_s = 32'(work_exp_r) - 32'd1;
    if (lz_s < 32'(SHIFT_PER_CYC)) begin
      shift_s = lz_s;
    end else begin
      shift_s = 32'(SHIFT_PER_CYC);
    end
    if (lim_s < shift_s) begin
      shift_s = lim_s;
    end else begin
      shift_s = shift_s;
    end
    shifted_s = work_sig_r << shift_s;
    shexp_s   = work_exp_r - EXW'(shift_s);

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          work_sign_nx = Sign_in;
          fin_sign_s   = Sign_in;
          if (Sum_in == {(SW+1){1'b0}}) begin
            fin_s      = 1'b1;
            fin_zero_s = 1'b1;
            state_nx   = DONE;
          end else if (Sum_in[SW]) begin
            fin_s     = 1'b1;
            fin_sig_s = {Sum_in[SW:2], |Sum_in[1:0]};
            fin_exp_s = e_inc_s;
            fin_ovf_s = (e_inc_s == EXP_ONES);
            state_nx  = DONE;
          end else if (Sum_in[HID]) begin
            fin_s     = 1'b1;
            fin_sig_s = Sum_in[HID:0];
            fin_exp_s = e_in_s;
            state_nx  = DONE;
          end else if (e_in_s == EXP_ONE) begin
            fin_s     = 1'b1;
            fin_sig_s = Sum_in[HID:0];
            fin_unf_s = 1'b1;
            state_nx  = DONE;
          end else begin
            work_sig_nx = Sum_in[HID:0];
            work_exp_nx = e_in_s;
            state_nx    = NORM;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      NORM: begin
        if (shifted_s[HID]) begin
          fin_s     = 1'b1;
          fin_sig_s = shifted_s;
          fin_exp_s = shexp_s;
          state_nx  = DONE;
        end else if (shexp_s == EXP_ONE) begin
          fin_s     = 1'b1;
          fin_sig_s = shifted_s;
          fin_unf_s = 1'b1;
          state_nx  = DONE;
        end else begin
          work_sig_nx = shifted_s;
          work_exp_nx = shexp_s;
          state_nx    = NORM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Working significand/exponent/sign while normalizing
  always_ff @(posedge CLK) begin
    if (RST) begin
      work_sig_r  <= {SW{1'b0}};
      work_exp_r  <= {EXW{1'b0}};
      work_sign_r <= 1'b0;
    end else begin
      work_sig_r  <= work_sig_nx;
      work_exp_r  <= work_exp_nx;
      work_sign_r <= work_sign_nx;
    end
  end

  // Registered handshake and result outputs; results hold after handoff, flags clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      MOut      <= {SW{1'b0}};
      Exp_out   <= {Exponent_WD{1'b0}};
      Sign_out  <= 1'b0;
      zero_flag <= 1'b0;
      ovf_flag  <= 1'b0;
      unf_flag  <= 1'b0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      if (fin_s) begin
        MOut      <= fin_sig_s;
        Exp_out   <= fin_exp_s[Exponent_WD-1:0];
        Sign_out  <= fin_sign_s;
        zero_flag <= fin_zero_s;
        ovf_flag  <= fin_ovf_s;
        unf_flag  <= fin_unf_s;
      end else if ((state_r == DONE) && out_ready) begin
        zero_flag <= 1'b0;
        ovf_flag  <= 1'b0;
        unf_flag  <= 1'b0;
      end else begin
        zero_flag <= zero_flag;
        ovf_flag  <= ovf_flag;
        unf_flag  <= unf_flag;
      end
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// Self-checking bench for fp_normalizer: directed test-plan cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_fp_normalizer;

  localparam int SPC = 4;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] Sum_in;
  logic [7:0]  Exp_in;
  logic        Sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] MOut;
  logic [7:0]  Exp_out;
  logic        Sign_out;
  logic        zero_flag;
  logic        ovf_flag;
  logic        unf_flag;

  int n_checks;
  int n_fail;

  fp_normalizer #(.Significant_WD(23), .Exponent_WD(8), .SHIFT_PER_CYC(SPC)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .Sum_in(Sum_in), .Exp_in(Exp_in), .Sign_in(Sign_in),
    .out_valid(out_valid), .out_ready(out_ready), .MOut(MOut),
    .Exp_out(Exp_out), .Sign_out(Sign_out), .zero_flag(zero_flag),
    .ovf_flag(ovf_flag), .unf_flag(unf_flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: total shift derived directly from the leading-zero count and exponent floor
  task automatic ref_model(input logic [27:0] sum, input logic [7:0] ein,
                           output logic [26:0] m, output logic [7:0] eo,
                           output logic z, output logic o, output logic u, output int lat);
    int e, lz, n;
    logic [27:0] t;
    e = (ein == 8'd0) ? 1 : int'(ein);
    z = 1'b0; o = 1'b0; u = 1'b0; lat = 1;
    if (sum == 28'd0) begin
      m = 27'd0; eo = 8'd0; z = 1'b1;
    end else if (sum[27]) begin
      t  = (sum >> 1) | (sum & 28'd1);
      m  = t[26:0];
      eo = 8'(e + 1);
      o  = ((e + 1) == 255);
    end else begin
      lz = 0;
      t  = sum;
      while (t[26] == 1'b0) begin
        t  = t << 1;
        lz = lz + 1;
      end
      n = (lz < e - 1) ? lz : e - 1;
      t = sum << n;
      m = t[26:0];
      if (n > 0) lat = 1 + (n + SPC - 1) / SPC;
      if (t[26]) begin
        eo = 8'(e - n);
      end else begin
        eo = 8'd0;
        u  = 1'b1;
      end
    end
  endtask

  // Drive one transaction, wait (bounded) for the result, hold DONE for 'hold' cycles, then hand off
  task automatic run_txn(input logic [27:0] sum, input logic [7:0] ein, input logic sgn, input int hold,
                         output logic [26:0] m, output logic [7:0] eo, output logic s,
                         output logic z, output logic o, output logic u, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
    end
    Sum_in = sum; Exp_in = ein; Sign_in = sgn; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    Sum_in = 28'($urandom); Exp_in = 8'($urandom); Sign_in = ~sgn;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    repeat (hold) begin
      @(posedge CLK); #1;
    end
    m = MOut; eo = Exp_out; s = Sign_out; z = zero_flag; o = ovf_flag; u = unf_flag;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    if (lat >= 40) begin
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({in_ready, out_valid, MOut, Exp_out, Sign_out, zero_flag, ovf_flag, unf_flag} !== {1'b1, 1'b0, 27'd0, 8'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b MOut=%h Exp_out=%0d flags=%b%b%b, required 1 0 0 0 000",
               in_ready, out_valid, MOut, Exp_out, zero_flag, ovf_flag, unf_flag);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_directed();
    logic [26:0] m; logic [7:0] eo; logic s, z, o, u; int lat;
    // carry
    run_txn(28'h8000000, 8'd100, 1'b0, 0, m, eo, s, z, o, u, lat);
    n_checks++;
    if ({m, eo, z, o, u} !== {27'h4000000, 8'd101, 3'b000} || lat !== 1) begin
      n_fail++;
      $display("FAIL carry: MOut=%h Exp=%0d zou=%b%b%b lat=%0d, required 4000000 101 000 lat 1", m, eo, z, o, u, lat);
    end
    // carry with guard bits, sticky kept
    run_txn(28'hC000007, 8'd100, 1'b1, 0, m, eo, s, z, o, u, lat);
    n_checks++;
    if ({m, eo, s} !== {27'h6000003, 8'd101, 1'b1}) begin
      n_fail++;
      $display("FAIL carry_sticky: MOut=%h Exp=%0d sign=%b, required 6000003 101 1", m, eo, s);
    end
    // cancellation, two NORM cycles
    run_txn(28'h0040000, 8'd100, 1'b0, 0, m, eo, s, z, o, u, lat);
    n_checks++;
    if ({m, eo, z, o, u} !== {27'h4000000, 8'd92, 3'b000} || lat !== 3) begin
      n_fail++;
      $display("FAIL cancel: MOut=%h Exp=%0d zou=%b%b%b lat=%0d, required 4000000 92 000 lat 3", m, eo, z, o, u, lat);
    end
    // underflow after one shift
    run_txn(28'h0000100, 8'd5, 1'b0, 0, m, eo, s, z, o, u, lat);
    n_checks++;
    if ({m, eo, z, o, u} !== {27'h0001000, 8'd0, 3'b001} || lat !== 2) begin
      n_fail++;
      $display("FAIL underflow: MOut=%h Exp=%0d zou=%b%b%b lat=%0d, required 0001000 0 001 lat 2", m, eo, z, o, u, lat);
    end
    // overflow
    run_txn(28'h8000000, 8'd254, 1'b0, 0, m, eo, s, z, o, u, lat);
    n_checks++;
    if ({eo, z, o, u} !== {8'd255, 3'b010}) begin
      n_fail++;
      $display("FAIL overflow: Exp=%0d zou=%b%b%b, required 255 010", eo, z, o, u);
    end
    // exact zero
    run_txn(28'h0000000, 8'd77, 1'b1, 0, m, eo, s, z, o, u, lat);
    n_checks++;
    if ({m, eo, s, z, o, u} !== {27'd0, 8'd0, 1'b1, 3'b100} || lat !== 1) begin
      n_fail++;
      $display("FAIL zero: MOut=%h Exp=%0d sign=%b zou=%b%b%b lat=%0d, required 0 0 1 100 lat 1", m, eo, s, z, o, u, lat);
    end
    // worst-case lz=26 with default shift width
    run_txn(28'h0000001, 8'd100, 1'b0, 0, m, eo, s, z, o, u, lat);
    n_checks++;
    if ({m, eo} !== {27'h4000000, 8'd74} || lat !== 8) begin
      n_fail++;
      $display("FAIL worst_case: MOut=%h Exp=%0d lat=%0d, required 4000000 74 lat 8", m, eo, lat);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    Sum_in = 28'hC000007; Exp_in = 8'd100; Sign_in = 1'b1; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(posedge CLK); #1;
      guard++;
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({out_valid, in_ready, MOut, Exp_out, Sign_out, zero_flag, ovf_flag, unf_flag} !==
          {1'b1, 1'b0, 27'h6000003, 8'd101, 1'b1, 3'b000}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: ov=%b ir=%b MOut=%h Exp=%0d sign=%b, required 1 0 6000003 101 1",
                 c, out_valid, in_ready, MOut, Exp_out, Sign_out);
      end
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL handoff: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_norm();
    logic [26:0] m; logic [7:0] eo; logic s, z, o, u; int lat;
    Sum_in = 28'h0000001; Exp_in = 8'd100; Sign_in = 1'b0; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_drop: in_ready=%b, required 0", in_ready);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid_norm: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL discarded: out_valid=%b, required 0", out_valid);
    end
    run_txn(28'h2000000, 8'd50, 1'b0, 0, m, eo, s, z, o, u, lat);
    n_checks++;
    if ({m, eo} !== {27'h4000000, 8'd49} || lat !== 2) begin
      n_fail++;
      $display("FAIL after_reset: MOut=%h Exp=%0d lat=%0d, required 4000000 49 lat 2", m, eo, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] m; logic [7:0] eo; logic s, z, o, u; int lat;
    run_txn(28'h4000001, 8'd0, 1'b0, 0, m, eo, s, z, o, u, lat);
    n_checks++;
    if ({m, eo, in_ready, out_valid} !== {27'h4000001, 8'd1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_first: MOut=%h Exp=%0d ir=%b ov=%b, required 4000001 1 1 0", m, eo, in_ready, out_valid);
    end
    run_txn(28'h1000000, 8'd1, 1'b1, 0, m, eo, s, z, o, u, lat);
    n_checks++;
    if ({m, eo, s, u} !== {27'h1000000, 8'd0, 1'b1, 1'b1} || lat !== 1) begin
      n_fail++;
      $display("FAIL b2b_unf_imm: MOut=%h Exp=%0d sign=%b unf=%b lat=%0d, required 1000000 0 1 1 lat 1", m, eo, s, u, lat);
    end
  endtask

  task automatic test_random();
    logic [27:0] sum; logic [7:0] ein; logic sgn;
    logic [26:0] m, em; logic [7:0] eo, ee; logic s, z, o, u, ez, eov, eu; int lat, elat, k;
    for (int i = 0; i < 200; i++) begin
      k = int'($urandom_range(0, 9));
      sum = 28'($urandom);
      if (k == 0) sum = 28'd0;
      else if (k <= 2) sum[27] = 1'b1;
      else if (k == 3) sum[27:26] = 2'b01;
      else sum = (sum & 28'h3FFFFFF) >> $urandom_range(0, 26);
      ein = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 254));
      sgn = 1'($urandom);
      ref_model(sum, ein, em, ee, ez, eov, eu, elat);
      run_txn(sum, ein, sgn, int'($urandom_range(0, 2)), m, eo, s, z, o, u, lat);
      n_checks++;
      if ({m, eo, s, z, o, u} !== {em, ee, sgn, ez, eov, eu} || lat !== elat) begin
        n_fail++;
        $display("FAIL random[%0d] sum=%h exp=%0d: got MOut=%h Exp=%0d s=%b zou=%b%b%b lat=%0d, required %h %0d %b %b%b%b lat %0d",
                 i, sum, ein, m, eo, s, z, o, u, lat, em, ee, sgn, ez, eov, eu, elat);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    Sum_in = 28'd0; Exp_in = 8'd0; Sign_in = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_norm();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
